// File: rtl/release_arbiter_pkg.sv
// release_arbiter_pkg: shared constants, FSM state type and a small helper
// for the release arbiter slice.
//   PHY_REG_NUM / PHY_REG_SEL : physical register count and tag width
//   RELARB_DEPTH              : default overflow FIFO depth
//   relarb_state_e            : arbiter FSM states (IDLE/WALK/DRAIN)
//   sat2()                    : min(n, 2), used for per-cycle pop counts
package release_arbiter_pkg;

  localparam int unsigned PHY_REG_NUM  = 64;
  localparam int unsigned PHY_REG_SEL  = $clog2(PHY_REG_NUM);
  localparam int unsigned RELARB_DEPTH = 8;

  typedef enum logic [1:0] {
    RELARB_IDLE  = 2'd0,
    RELARB_WALK  = 2'd1,
    RELARB_DRAIN = 2'd2
  } relarb_state_e;

  function automatic logic [1:0] sat2(input int unsigned n);
    return (n >= 2) ? 2'd2 : n[1:0];
  endfunction

endpackage

// File: rtl/relarb_fifo.sv
// relarb_fifo: in-order overflow buffer for the release arbiter.
// Accepts up to four tags per cycle (sparse valids are compacted, lowest
// index first) and retires up to two from the head per cycle.
// Ports:
//   clk, reset          clock, async active-low reset
//   push_tag/push_valid 4 candidate tags, enqueued in index order if valid
//   pop_cnt             number of head entries consumed this cycle (0..2)
//   head_tag            the two oldest entries (meaningful only up to count)
//   count               registered occupancy
// The caller guarantees no overflow and pop_cnt <= count.
module relarb_fifo
  import release_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = PHY_REG_SEL,
  parameter int unsigned DEPTH = RELARB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TAG_W-1:0]         push_tag   [4],
  input  logic                     push_valid [4],
  input  logic [1:0]               pop_cnt,
  output logic [TAG_W-1:0]         head_tag   [2],
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;

  logic [TAG_W-1:0] cmp_tag [4];
  logic [2:0]       n_push;

  // Pack valid pushes into consecutive slots so the tail advances densely.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) cmp_tag[i] = '0;
    n_push = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (push_valid[i]) begin
        cmp_tag[n_push[1:0]] = push_tag[i];
        n_push               = n_push + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < n_push) mem[tail_q + PTR_W'(i)] <= cmp_tag[i];
    end
  end

  // Pointers are PTR_W bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_q + PTR_W'(pop_cnt);
      tail_q <= tail_q + PTR_W'(n_push);
      cnt_q  <= cnt_q + CNT_W'(n_push) - CNT_W'(pop_cnt);
    end
  end

  assign head_tag[0] = mem[head_q];
  assign head_tag[1] = mem[head_q + PTR_W'(1)];
  assign count       = cnt_q;

endmodule

// File: rtl/release_arbiter.sv
// release_arbiter: merges commit releases (never stalled) and squash-walk
// releases (back-pressured) onto the freelist's two registered release
// ports, buffering the excess in an in-order FIFO.
// Ports:
//   clk, reset                 clock, async active-low reset
//   cm_tag1/2, cm_valid1/2     commit-released tags, always accepted
//   sq_start                   misprediction pulse, starts the squash walk
//   sq_tag1/2, sq_valid1/2     squash-released tags
//   sq_last                    marks the final squash beat
//   sq_ready                   squash beat accept (from registered state)
//   rel_tag1/2, rel_valid1/2   registered release outputs, slot 1 fills first
//   recovering                 high while the FSM is not IDLE
//   pending_cnt                registered FIFO occupancy
//   err                        sticky protocol error
// Build option: define RELARB_CHECK_EN to synthesize the protocol checker
// driving err; otherwise err is tied to 0.
module release_arbiter
  import release_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = PHY_REG_SEL,
  parameter int unsigned DEPTH = RELARB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TAG_W-1:0]       cm_tag1,
  input  logic [TAG_W-1:0]       cm_tag2,
  input  logic                   cm_valid1,
  input  logic                   cm_valid2,
  input  logic                   sq_start,
  input  logic [TAG_W-1:0]       sq_tag1,
  input  logic [TAG_W-1:0]       sq_tag2,
  input  logic                   sq_valid1,
  input  logic                   sq_valid2,
  input  logic                   sq_last,
  output logic                   sq_ready,
  output logic [TAG_W-1:0]       rel_tag1,
  output logic [TAG_W-1:0]       rel_tag2,
  output logic                   rel_valid1,
  output logic                   rel_valid2,
  output logic                   recovering,
  output logic [$clog2(DEPTH):0] pending_cnt,
  output logic                   err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  relarb_state_e state_q, state_d;

  logic             beat_acc;
  logic [TAG_W-1:0] raw_tag   [4];
  logic             raw_vld   [4];
  logic             push_vld  [4];
  logic [TAG_W-1:0] fifo_head [2];
  logic [1:0]       pop_n;
  logic [1:0]       slot;
  logic [TAG_W-1:0] rel_tag_d [2];
  logic             rel_vld_d [2];

  // Two free entries are needed because a beat can add up to 4 while
  // only 2 leave per cycle.
  assign sq_ready   = (state_q == RELARB_WALK) && (pending_cnt <= CNT_W'(DEPTH - 2));
  assign beat_acc   = (sq_valid1 | sq_valid2 | sq_last) & sq_ready;
  assign recovering = (state_q != RELARB_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RELARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RELARB_IDLE:  if (sq_start)            state_d = RELARB_WALK;
      RELARB_WALK:  if (beat_acc && sq_last) state_d = RELARB_DRAIN;
      RELARB_DRAIN: if (pending_cnt == '0)   state_d = RELARB_IDLE;
      default:                               state_d = RELARB_IDLE;
    endcase
  end

  // New candidates in age order: commit before squash, slot 1 before 2.
  always_comb begin
    raw_tag[0] = cm_tag1;
    raw_tag[1] = cm_tag2;
    raw_tag[2] = sq_tag1;
    raw_tag[3] = sq_tag2;
    raw_vld[0] = cm_valid1;
    raw_vld[1] = cm_valid2;
    raw_vld[2] = sq_valid1 & beat_acc;
    raw_vld[3] = sq_valid2 & beat_acc;
  end

  // FIFO head wins the release slots first; remaining slots take the oldest
  // valid new candidates, and everything else is pushed behind the FIFO.
  always_comb begin
    pop_n = sat2(32'(pending_cnt));
    for (int unsigned i = 0; i < 2; i++) begin
      rel_tag_d[i] = '0;
      rel_vld_d[i] = 1'b0;
    end
    for (int unsigned i = 0; i < 4; i++) push_vld[i] = 1'b0;
    if (pop_n != 2'd0) begin
      rel_tag_d[0] = fifo_head[0];
      rel_vld_d[0] = 1'b1;
    end
    if (pop_n == 2'd2) begin
      rel_tag_d[1] = fifo_head[1];
      rel_vld_d[1] = 1'b1;
    end
    slot = pop_n;
    for (int unsigned i = 0; i < 4; i++) begin
      if (raw_vld[i]) begin
        if (slot < 2'd2) begin
          rel_tag_d[slot[0]] = raw_tag[i];
          rel_vld_d[slot[0]] = 1'b1;
          slot               = slot + 2'd1;
        end else begin
          push_vld[i] = 1'b1;
        end
      end
    end
  end

  relarb_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_tag   (raw_tag),
    .push_valid (push_vld),
    .pop_cnt    (pop_n),
    .head_tag   (fifo_head),
    .count      (pending_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_tag1   <= '0;
      rel_tag2   <= '0;
      rel_valid1 <= 1'b0;
      rel_valid2 <= 1'b0;
    end else begin
      rel_tag1   <= rel_tag_d[0];
      rel_tag2   <= rel_tag_d[1];
      rel_valid1 <= rel_vld_d[0];
      rel_valid2 <= rel_vld_d[1];
    end
  end

`ifdef RELARB_CHECK_EN
  logic err_q;
  logic err_set;

  assign err_set = (sq_start && (state_q != RELARB_IDLE))
                || ((sq_valid1 | sq_valid2 | sq_last) && (state_q != RELARB_WALK))
                || (cm_valid1 && cm_valid2 && (cm_tag1 == cm_tag2))
                || (rel_valid1 && rel_valid2 && (rel_tag1 == rel_tag2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | err_set;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_release_arbiter.sv
module tb_release_arbiter;

  localparam int TW    = 6;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [TW-1:0] cm_tag1, cm_tag2, sq_tag1, sq_tag2;
  logic          cm_valid1, cm_valid2, sq_start, sq_valid1, sq_valid2, sq_last;
  logic          sq_ready;
  logic [TW-1:0] rel_tag1, rel_tag2;
  logic          rel_valid1, rel_valid2, recovering, err;
  logic [$clog2(DEPTH):0] pending_cnt;

  release_arbiter #(.TAG_W(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cm_tag1(cm_tag1), .cm_tag2(cm_tag2), .cm_valid1(cm_valid1), .cm_valid2(cm_valid2),
    .sq_start(sq_start), .sq_tag1(sq_tag1), .sq_tag2(sq_tag2),
    .sq_valid1(sq_valid1), .sq_valid2(sq_valid2), .sq_last(sq_last), .sq_ready(sq_ready),
    .rel_tag1(rel_tag1), .rel_tag2(rel_tag2), .rel_valid1(rel_valid1), .rel_valid2(rel_valid2),
    .recovering(recovering), .pending_cnt(pending_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a plain ordered list of outstanding tags.
  // Phase 0 = idle, 1 = walking, 2 = draining.
  int unsigned mq [16];
  int          mq_n = 0;
  int          m_phase = 0;
  bit          m_v1 = 0, m_v2 = 0, m_err = 0;
  int unsigned m_t1 = 0, m_t2 = 0;

  function automatic bit model_ready();
    return (m_phase == 1) && (mq_n <= DEPTH - 2);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq_n <= 0; m_phase <= 0; m_v1 <= 0; m_v2 <= 0; m_t1 <= 0; m_t2 <= 0; m_err <= 0;
    end else begin
      automatic int unsigned c [16];
      automatic int unsigned r [16];
      automatic int n = 0;
      automatic bit acc = (sq_valid1 | sq_valid2 | sq_last) && model_ready();
      for (int i = 0; i < 16; i++) begin c[i] = 0; r[i] = 0; end
      for (int i = 0; i < mq_n; i++) begin c[n] = mq[i]; n++; end
      if (cm_valid1)        begin c[n] = cm_tag1; n++; end
      if (cm_valid2)        begin c[n] = cm_tag2; n++; end
      if (acc && sq_valid1) begin c[n] = sq_tag1; n++; end
      if (acc && sq_valid2) begin c[n] = sq_tag2; n++; end
      m_v1 <= (n >= 1);
      m_t1 <= (n >= 1) ? c[0] : 0;
      m_v2 <= (n >= 2);
      m_t2 <= (n >= 2) ? c[1] : 0;
      for (int i = 2; i < n; i++) r[i-2] = c[i];
      mq   <= r;
      mq_n <= (n > 2) ? n - 2 : 0;
      case (m_phase)
        0: if (sq_start) m_phase <= 1;
        1: if (acc && sq_last) m_phase <= 2;
        default: if (mq_n == 0) m_phase <= 0;
      endcase
`ifdef RELARB_CHECK_EN
      if ((sq_start && m_phase != 0) || ((sq_valid1 | sq_valid2 | sq_last) && m_phase != 1) ||
          (cm_valid1 && cm_valid2 && cm_tag1 == cm_tag2) || (m_v1 && m_v2 && m_t1 == m_t2))
        m_err <= 1;
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset && chk_on) begin
      chk("rel_valid1", rel_valid1, m_v1);
      chk("rel_valid2", rel_valid2, m_v2);
      if (m_v1) chk("rel_tag1", rel_tag1, m_t1);
      if (m_v2) chk("rel_tag2", rel_tag2, m_t2);
      chk("pending_cnt", pending_cnt, mq_n);
      chk("recovering", recovering, m_phase != 0);
      chk("sq_ready", sq_ready, model_ready());
      chk("err", err, m_err);
    end
  end

  // Release stream capture for the end-to-end ordering check.
  bit          collect = 0;
  int unsigned out_q [$];
  int unsigned inj_q [$];
  always @(negedge clk) begin
    if (collect) begin
      if (rel_valid1) out_q.push_back(rel_tag1);
      if (rel_valid2) out_q.push_back(rel_tag2);
    end
  end

  task automatic clr();
    cm_tag1 = '0; cm_tag2 = '0; cm_valid1 = 0; cm_valid2 = 0;
    sq_tag1 = '0; sq_tag2 = '0; sq_valid1 = 0; sq_valid2 = 0;
    sq_start = 0; sq_last = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cm(input int t1, input bit v1, input int t2, input bit v2);
    cm_tag1 = TW'(t1); cm_valid1 = v1; cm_tag2 = TW'(t2); cm_valid2 = v2;
  endtask

  task automatic drive_sq(input int t1, input bit v1, input int t2, input bit v2, input bit last);
    sq_tag1 = TW'(t1); sq_valid1 = v1; sq_tag2 = TW'(t2); sq_valid2 = v2; sq_last = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ct, st, first_full, k;
    bit acc;
    clr();
    reset = 0;
    repeat (2) tick();
    chk("reset_pending", pending_cnt, 0);
    chk("reset_rv1", rel_valid1, 0);
    chk("reset_rv2", rel_valid2, 0);
    chk("reset_recov", recovering, 0);
    chk("reset_err", err, 0);
    reset = 1;
    chk_on = 1;
    tick();

    // Commit only, empty FIFO.
    drive_cm(5, 1, 9, 1); tick(); clr();
    chk("cm_rv1", rel_valid1, 1); chk("cm_rt1", rel_tag1, 5);
    chk("cm_rv2", rel_valid2, 1); chk("cm_rt2", rel_tag2, 9);
    chk("cm_pend", pending_cnt, 0);
    tick();
    chk("idle_rv1", rel_valid1, 0); chk("idle_rv2", rel_valid2, 0);

    // Compaction of a sparse commit pair.
    drive_cm(0, 0, 7, 1); tick(); clr();
    chk("cmp_rv1", rel_valid1, 1); chk("cmp_rt1", rel_tag1, 7); chk("cmp_rv2", rel_valid2, 0);

    // Mixed commit + squash beat.
    sq_start = 1; tick(); clr();
    chk("walk_recov", recovering, 1); chk("walk_ready", sq_ready, 1);
    drive_cm(3, 1, 4, 1); drive_sq(12, 1, 13, 1, 0); tick(); clr();
    chk("mix_rt1", rel_tag1, 3); chk("mix_rt2", rel_tag2, 4); chk("mix_pend", pending_cnt, 2);
    tick();
    chk("mix2_rt1", rel_tag1, 12); chk("mix2_rt2", rel_tag2, 13);
    chk("mix2_rv2", rel_valid2, 1); chk("mix2_pend", pending_cnt, 0);

    // Empty final beat ends the walk; one DRAIN cycle before IDLE.
    drive_sq(0, 0, 0, 0, 1); tick(); clr();
    chk("drain_recov", recovering, 1); chk("drain_ready", sq_ready, 0);
    tick();
    chk("idle_recov", recovering, 0);

    // Back-pressure: commit and squash both at full rate.
    sq_start = 1; tick(); clr();
    collect = 1;
    ct = 20; st = 40; first_full = -1;
    for (k = 0; k < 7; k++) begin
      drive_cm(ct, 1, ct + 1, 1);
      drive_sq(st, 1, st + 1, 1, 0);
      acc = model_ready();
      inj_q.push_back(ct); inj_q.push_back(ct + 1);
      if (acc) begin inj_q.push_back(st); inj_q.push_back(st + 1); end
      if (!acc && first_full < 0) begin
        first_full = k;
        chk("bp_full_cnt", pending_cnt, 8);
        chk("bp_full_ready", sq_ready, 0);
      end
      tick();
      ct += 2;
      if (acc) st += 2;
    end
    clr();
    chk("bp_first_full", first_full, 4);
    chk("bp_hold_cnt", pending_cnt, 8);
    for (k = 0; k < 10; k++) begin
      drive_sq(0, 0, 0, 0, 1);
      acc = model_ready();
      tick();
      if (acc) break;
    end
    clr();
    chk("bp_last_acc", acc, 1);
    for (k = 0; k < 20 && recovering; k++) tick();
    chk("bp_drained", recovering, 0);
    chk("bp_empty", pending_cnt, 0);
    collect = 0;
    chk("order_len", out_q.size(), inj_q.size());
    for (int i = 0; i < out_q.size() && i < inj_q.size(); i++) chk("order", out_q[i], inj_q[i]);

    // Async reset in WALK with five tags buffered.
    sq_start = 1; tick(); clr();
    drive_cm(50, 1, 51, 1); drive_sq(52, 1, 0, 0, 0); tick();
    drive_cm(53, 1, 54, 1); drive_sq(55, 1, 56, 1, 0); tick();
    drive_cm(57, 1, 58, 1); drive_sq(59, 1, 60, 1, 0); tick(); clr();
    chk("pre_rst_pend", pending_cnt, 5);
    chk("pre_rst_recov", recovering, 1);
    reset = 0;
    #1;
    chk("rst_rv1", rel_valid1, 0); chk("rst_rv2", rel_valid2, 0);
    chk("rst_pend", pending_cnt, 0); chk("rst_recov", recovering, 0);
    tick();
    reset = 1;
    tick();

    // Stray squash valid while idle.
    drive_sq(30, 1, 0, 0, 0); tick(); clr();
`ifdef RELARB_CHECK_EN
    chk("err_stray", err, 1);
`else
    chk("err_off", err, 0);
`endif
    chk("stray_pend", pending_cnt, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
